// File: rtl/mux.sv
// mux: registered 2:1 data multiplexer; z <= sel ? b : a, asynchronous reset to RESET_VAL.
// Revision: 1.0
`default_nettype none

module mux #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel
);

  logic [WIDTH-1:0] z_q;
  logic [WIDTH-1:0] z_d;

  // Default to a so that an X or Z select falls through to a instead of poisoning z.
  always_comb begin
    z_d = a;
    if (sel == 1'b1) begin
      z_d = b;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      z_q <= RESET_VAL;
    end else begin
      z_q <= z_d;
    end
  end

  assign z = z_q;

endmodule

`default_nettype wire

// File: tb/tb_mux.sv
// tb_mux: scoreboard bench for mux; directed plan followed by randomized traffic against a reference model.
`default_nettype none

module tb_mux;

  localparam int unsigned      WIDTH     = 8;
  localparam logic [WIDTH-1:0] RESET_VAL = 8'h00;

  typedef struct {
    logic [WIDTH-1:0] exp;
    string            tag;
  } exp_t;

  logic             i_clk;
  logic             i_reset;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;

  exp_t q[$];
  int   total;
  int   bad;
  int   cyc;

  mux #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .z      (z),
    .a      (a),
    .b      (b),
    .sel    (sel)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: what z must be just after the next rising edge given the inputs held across it.
  function automatic logic [WIDTH-1:0] model(input logic rst, input logic s,
                                             input logic [WIDTH-1:0] av,
                                             input logic [WIDTH-1:0] bv);
    if (rst)
      return RESET_VAL;
    return (s === 1'b1) ? bv : av;
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic s, input logic rst, input string tag);
    exp_t e;
    @(negedge i_clk);
    a       = av;
    b       = bv;
    sel     = s;
    i_reset = rst;
    e.exp   = model(rst, s, av, bv);
    e.tag   = tag;
    q.push_back(e);
  endtask

  // Monitor: every edge with an outstanding expectation is compared in order.
  always @(posedge i_clk) begin
    cyc++;
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.tag, z, e.exp);
    end
  end

  initial begin
    exp_t e;
    total   = 0;
    bad     = 0;
    cyc     = 0;
    i_reset = 1'b0;
    a       = 8'd120;
    b       = 8'd216;
    sel     = 1'b1;

    #1 i_reset = 1'b1;
    #1 check("reset_immediate", z, RESET_VAL);

    repeat (3) drive(8'd120, 8'd216, 1'b1, 1'b1, "reset_hold");
    drive(8'd120, 8'd216, 1'b1, 1'b0, "reset_release");
    drive(8'd120, 8'd216, 1'b0, 1'b0, "sel_a");
    drive(8'd120, 8'd254, 1'b0, 1'b0, "b_change_ignored");
    drive(8'd120, 8'd216, 1'b1, 1'b0, "sel_b");
    drive(8'd120, 8'd216, 1'b0, 1'b0, "back_to_a");
    drive(8'd200, 8'd216, 1'b0, 1'b0, "a_update");
    drive(8'd200, 8'd254, 1'b1, 1'b0, "b_and_sel_same_cycle");
    drive(8'd200, 8'd254, 1'bx, 1'b0, "sel_unknown");
    drive(8'd200, 8'd254, 1'b1, 1'b0, "pre_mid_reset");

    // Pulse reset between edges; the pending expectation covers the edge after release.
    @(negedge i_clk);
    a     = 8'd200;
    b     = 8'd254;
    sel   = 1'b1;
    e.exp = model(1'b0, 1'b1, 8'd200, 8'd254);
    e.tag = "after_mid_reset";
    q.push_back(e);
    #1 i_reset = 1'b1;
    #1 check("mid_reset_async", z, RESET_VAL);
    #1 i_reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      logic rst_r;
      rst_r = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0)
        drive(a, b, sel, rst_r, "rand_hold");
      else
        drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), rst_r, "rand");
    end
    drive(a, b, sel, 1'b0, "final");

    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending expected=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
